// File: rtl/mc_fsm_ctrl.sv
// Multicycle MIPS control FSM with a clocked state register, memory-ready
// wait states and a trap state for illegal opcodes.
//
// state | meaning
// 0     | FETCH   read instruction, PC+4 (enables gated by mem_ready)
// 1     | DECODE  register read, branch target calc, dispatch on op
// 2     | MEMADR  effective address for LW/SW
// 3     | MEMRD   data read, waits for mem_ready
// 4     | MEMWB   load writeback
// 5     | MEMWR   data write, waits for mem_ready
// 6     | EXEC    R-type ALU op
// 7     | ALUWB   R-type writeback
// 8     | BRANCH  BEQ/BNE compare and conditional PC write
// 9     | JUMP    unconditional PC write
// 10    | ADDIEX  immediate add
// 11    | ADDIWB  immediate writeback
// 13    | TRAP    illegal opcode, held until reset
module mc_fsm_ctrl #(
  parameter int              OP_W     = 6,
  parameter int              STATE_W  = 4,
  parameter int              MEM_WAIT = 1,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OP_W-1:0] OP_LW    = 6'h23,
  parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
  parameter logic [OP_W-1:0] OP_BNE   = 6'h05,
  parameter logic [OP_W-1:0] OP_J     = 6'h02,
  parameter logic [OP_W-1:0] OP_ADDI  = 6'h08
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               illegal,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_op,
  output logic [1:0]         alu_src_b
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(13);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               r_is_bne;
  logic               w_mem_ready;

  assign w_mem_ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // Branch polarity is captured in DECODE so op only matters while decoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_is_bne <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_is_bne <= (op == OP_BNE);
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)       w_next = S_MEMADR;
        else if (op == OP_RTYPE)              w_next = S_EXEC;
        else if (op == OP_BEQ || op == OP_BNE) w_next = S_BRANCH;
        else if (op == OP_J)                  w_next = S_JUMP;
        else if (op == OP_ADDI)               w_next = S_ADDIEX;
        else                                  w_next = S_TRAP;
      end
      S_MEMADR: begin
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_TRAP;
      end
      S_MEMRD:  w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low in the same cycle, not just at the next edge.
  always_comb begin
    state         = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    illegal       = 1'b0;
    pc_src        = 2'b00;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = w_mem_ready;
          pc_write  = w_mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          branch_ne     = r_is_bne;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_TRAP:   illegal = 1'b1;
        default: begin
          state = r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_fsm_ctrl.sv
// Scoreboard bench for mc_fsm_ctrl: instructions are expanded into per-cycle
// stimulus plus expected state/controls; a monitor checks each cycle.
module tb_mc_fsm_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic [3:0] state;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst, illegal;
  logic [1:0] pc_src, alu_op, alu_src_b;

  mc_fsm_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .state(state),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .reg_write(reg_write), .reg_dst(reg_dst), .illegal(illegal),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02,
                         OP_ADDI = 6'h08;

  typedef struct {
    bit         r;
    logic [5:0] o;
    bit         m;
    int         st;
    logic [17:0] c;
  } plan_t;

  typedef struct {
    int          st;
    logic [17:0] c;
  } exp_t;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {pc_write, pc_write_cond, branch_ne, iord, mem_read,
                     mem_write, ir_write, mem_to_reg, alu_src_a, reg_write,
                     reg_dst, illegal, pc_src, alu_op, alu_src_b};

  // Control word each state should present, straight from the state table.
  function automatic logic [17:0] exp_ctrl(int st, bit mr, bit bne);
    bit pw = 0, pwc = 0, bn = 0, io = 0, mrd = 0, mwr = 0;
    bit irw = 0, m2r = 0, asa = 0, rw = 0, rd = 0, ill = 0;
    logic [1:0] ps = 2'b00, ao = 2'b00, asb = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin asa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; bn = bne; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      13: ill = 1;
      default: ;
    endcase
    return {pw, pwc, bn, io, mrd, mwr, irw, m2r, asa, rw, rd, ill, ps, ao, asb};
  endfunction

  function automatic bit is_legal(logic [5:0] o);
    return o == OP_RTYPE || o == OP_LW || o == OP_SW || o == OP_BEQ ||
           o == OP_BNE || o == OP_J || o == OP_ADDI;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic add(bit r, logic [5:0] o, bit m, int st, logic [17:0] c);
    plan_t p;
    p.r = r; p.o = o; p.m = m; p.st = st; p.c = c;
    plan_q.push_back(p);
  endtask

  task automatic add_st(logic [5:0] o, bit m, int st, bit bne);
    add(0, o, m, st, exp_ctrl(st, m, bne));
  endtask

  // One instruction: fw fetch waits, mw memory waits, optional reset during
  // the memory phase, hold cycles in trap before a reset releases it.
  task automatic gen_instr(logic [5:0] o, int fw, int mw, bit abort, int hold);
    for (int i = 0; i < fw; i++) add_st(rop(), 0, 0, 0);
    add_st(rop(), 1, 0, 0);
    add_st(o, rb(), 1, 0);
    if (!is_legal(o)) begin
      for (int i = 0; i < hold; i++) add_st(rop(), rb(), 13, 0);
      add(1, rop(), rb(), 0, '0);
    end else if (o == OP_LW || o == OP_SW) begin
      int mst = (o == OP_LW) ? 3 : 5;
      add_st(o, rb(), 2, 0);
      for (int i = 0; i < mw; i++) add_st(o, 0, mst, 0);
      if (abort) begin
        add(1, o, rb(), 0, '0);
      end else begin
        add_st(o, 1, mst, 0);
        if (o == OP_LW) add_st(o, rb(), 4, 0);
      end
    end else if (o == OP_RTYPE) begin
      add_st(o, rb(), 6, 0);
      add_st(o, rb(), 7, 0);
    end else if (o == OP_ADDI) begin
      add_st(o, rb(), 10, 0);
      add_st(o, rb(), 11, 0);
    end else if (o == OP_BEQ || o == OP_BNE) begin
      add_st(o, rb(), 8, o == OP_BNE);
    end else begin
      add_st(o, rb(), 9, 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (int'(state) != e.st) begin
          errors++;
          $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
        end
        checks++;
        if (dut_ctrl !== e.c) begin
          errors++;
          $display("FAIL ctrl t=%0t state=%0d got=%b exp=%b", $time, e.st,
                   dut_ctrl, e.c);
        end
      end
    end
  end

  initial begin : driver
    plan_t p;
    logic [5:0] ops[7];
    logic [5:0] o;
    exp_t e;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
    rst = 1'b1; op = '0; mem_ready = 1'b1;

    add(1, 0, 1, 0, '0);
    add(1, 0, 1, 0, '0);
    gen_instr(OP_LW,   0, 0, 0, 0);
    gen_instr(OP_LW,   0, 3, 0, 0);
    gen_instr(OP_BEQ,  0, 0, 0, 0);
    gen_instr(OP_BNE,  0, 0, 0, 0);
    gen_instr(OP_ADDI, 0, 0, 0, 0);
    gen_instr(6'h3F,   0, 0, 0, 10);
    gen_instr(OP_SW,   0, 1, 1, 0);
    gen_instr(OP_SW,   2, 2, 0, 0);
    gen_instr(OP_RTYPE, 1, 0, 0, 0);
    gen_instr(OP_J,    0, 0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do o = rop(); while (is_legal(o));
      end else begin
        o = ops[$urandom_range(0, 6)];
      end
      gen_instr(o, $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 7) == 0, $urandom_range(1, 4));
    end

    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      rst = p.r; op = p.o; mem_ready = p.m;
      e.st = p.st; e.c = p.c;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
